// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locking arbiter for the write port of a
// dual-clock FIFO. It lives in the FIFO write-clock domain. While a grant is
// held it forwards the granted requester's beats and throttles them against
// fifo_full_i.
//
// Handshake: a beat moves when the granted requester's req_valid_i is high and
// fifo_full_i is low. In that cycle req_ready_o[g] and fifo_wr_en_o are both
// high. The requester must hold valid/data/last stable until it sees ready.
//
// Optional feature, enabled by defining FIFO_WR_ARB_STALL_CNT_EN: a saturating
// 16-bit counter of cycles where the granted requester is blocked by a full
// FIFO. It adds the ports stall_clr_i and stall_cnt_o.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    input  logic                          stall_clr_i,
    output logic [15:0]                   stall_cnt_o,
`endif
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW1 = IW + 1;
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                  pick_found;
    logic [IW-1:0]         pick_idx;
    logic [IW1-1:0]        cand;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  in_burst;
    logic                  accept;
    logic                  release_now;

    // Round-robin pick: first valid requester searching upward from rr_ptr_q
    // with wrap. Depends only on registered pointer and valids, never on full.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + IW1'(i);
            if (cand >= IW1'(NUM_REQ)) begin
                cand = cand - IW1'(NUM_REQ);
            end
            if (!pick_found && req_valid_i[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    // Beat path for the granted requester: accept, release and output muxing.
    always_comb begin
        in_burst    = (state_q == BURST);
        sel_valid   = req_valid_i[gidx_q];
        sel_last    = req_last_i[gidx_q];
        sel_data    = req_data_i[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
        accept      = in_burst & sel_valid & ~fifo_full_i;
        // A full stall (valid high, full high) never releases; only an
        // accepted last/maximum beat or an idle requester on a non-full FIFO.
        release_now = in_burst &
                      ((accept & (sel_last | (cnt_q == CW'(MAX_BURST - 1)))) |
                       (~sel_valid & ~fifo_full_i));

        fifo_wr_en_o   = accept;
        req_ready_o    = accept ? grant_q : '0;
        fifo_wr_data_o = in_burst ? sel_data : '0;
        grant_o        = grant_q;
        busy_o         = in_burst;
    end

    // Next-state logic for the IDLE/BURST controller.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d           = BURST;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    gidx_d            = pick_idx;
                    cnt_d             = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (release_now) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Controller state register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles where the granted requester is blocked by full.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (stall_clr_i) begin
            stall_cnt_q <= '0;
        end else if (in_burst && sel_valid && fifo_full_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios with hand-computed expected
// write order, grant sequence and burst lengths.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int MB = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              wr_en;
    logic [DW-1:0]     wr_data;
    logic [NR-1:0]     grant;
    logic              busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic              stall_clr;
    logic [15:0]       stall_cnt;
`endif

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        #3_000_000;
`else
        #500_000;
`endif
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_last_i    (req_last),
        .req_ready_o   (req_ready),
        .fifo_full_i   (fifo_full),
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        .stall_clr_i   (stall_clr),
        .stall_cnt_o   (stall_cnt),
`endif
        .fifo_wr_en_o  (wr_en),
        .fifo_wr_data_o(wr_data),
        .grant_o       (grant),
        .busy_o        (busy)
    );

    // Requester sources: per-requester beat lists and read pointers.
    logic [DW-1:0] src_data [NR][64];
    logic          src_last [NR][64];
    int            src_len  [NR];
    int            src_ptr  [NR];

    // Scoreboard state.
    logic [DW-1:0] exp_q[$];
    logic [NR-1:0] gnt_log[$];
    int            len_log[$];
    logic [NR-1:0] prev_gnt  = '0;
    int            burst_len = 0;
    int            n_vec     = 0;
    int            n_err     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        for (int k = 0; k < NR; k++) begin
            if (src_ptr[k] < src_len[k]) begin
                req_valid[k]         = 1'b1;
                req_data[k*DW +: DW] = src_data[k][src_ptr[k]];
                req_last[k]          = src_last[k][src_ptr[k]];
            end else begin
                req_valid[k]         = 1'b0;
                req_data[k*DW +: DW] = '0;
                req_last[k]          = 1'b0;
            end
        end
    endtask

    task automatic push_beat(input int k, input logic [DW-1:0] d, input logic l);
        src_data[k][src_len[k]] = d;
        src_last[k][src_len[k]] = l;
        src_len[k]++;
    endtask

    // One clock: monitor at negedge, then advance sources after posedge.
    task automatic tick();
        logic [NR-1:0] rd;
        @(negedge clk);
        rd = req_ready;
        if (wr_en) begin
            if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
            else check("wr_data", wr_data, exp_q.pop_front());
        end
        if (grant != prev_gnt) begin
            if (prev_gnt != '0) len_log.push_back(burst_len);
            if (grant != '0) begin
                gnt_log.push_back(grant);
                if (prev_gnt != '0) check("gap", prev_gnt, 0);
            end
            burst_len = 0;
        end
        if (wr_en) burst_len++;
        prev_gnt = grant;
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) if (rd[k]) src_ptr[k]++;
        drive_src();
        #1;
    endtask

    task automatic check_logs(input string tag, input logic [NR-1:0] g0, input logic [NR-1:0] g1,
                              input logic [NR-1:0] g2, input logic [NR-1:0] g3,
                              input int l0, input int l1, input int l2, input int l3, input int n);
        logic [NR-1:0] ge [4];
        int            le [4];
        ge[0] = g0; ge[1] = g1; ge[2] = g2; ge[3] = g3;
        le[0] = l0; le[1] = l1; le[2] = l2; le[3] = l3;
        check({tag, "_drain"}, exp_q.size(), 0);
        check({tag, "_ngnt"}, gnt_log.size(), n);
        check({tag, "_nlen"}, len_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < gnt_log.size()) check({tag, "_gnt"}, gnt_log[i], ge[i]);
            if (i < len_log.size()) check({tag, "_len"}, len_log[i], le[i]);
        end
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        len_log.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        fifo_full = 1'b0;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        stall_clr = 1'b0;
`endif
        for (int k = 0; k < NR; k++) begin
            src_len[k] = 0;
            src_ptr[k] = 0;
        end
        drive_src();
        repeat (3) tick();

        // Reset state.
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_wren", wr_en, 0);
        check("rst_ready", req_ready, 0);
        check("rst_data", wr_data, 0);
        rst_n = 1'b1;
        tick();
        check("idle_grant", grant, 0);

        // Single requester, three-beat packet.
        push_beat(0, 16'h0A01, 1'b0);
        push_beat(0, 16'h0A02, 1'b0);
        push_beat(0, 16'h0A03, 1'b1);
        exp_q.push_back(16'h0A01); exp_q.push_back(16'h0A02); exp_q.push_back(16'h0A03);
        drive_src();
        #1;
        check("t1_pre_grant", grant, 0);
        tick();
        check("t1_grant", grant, 4'b0001);
        check("t1_busy", busy, 1);
        check("t1_wren0", wr_en, 1);
        check("t1_data0", wr_data, 16'h0A01);
        tick();
        check("t1_data1", wr_data, 16'h0A02);
        tick();
        check("t1_data2", wr_data, 16'h0A03);
        check("t1_ready2", req_ready, 4'b0001);
        tick();
        check("t1_rel_grant", grant, 0);
        check("t1_rel_busy", busy, 0);
        check("t1_rel_wren", wr_en, 0);

        // rr_ptr is now 1: req1 beats req0.
        push_beat(0, 16'h0B00, 1'b1);
        push_beat(1, 16'h0B01, 1'b1);
        exp_q.push_back(16'h0B01); exp_q.push_back(16'h0B00);
        drive_src();
        tick();
        check("t1_rr_grant", grant, 4'b0010);
        tick();
        check("t1_rr_gap", grant, 0);
        tick();
        check("t1_rr_next", grant, 4'b0001);
        repeat (3) tick();
        check("t1_rr_drain", exp_q.size(), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Two requesters with 2-beat packets, rr_ptr=0: order 0,2,0,2.
        clear_logs();
        for (int j = 0; j < 2; j++) begin
            push_beat(0, 16'h0100 + 16'(2*j), 1'b0);
            push_beat(0, 16'h0101 + 16'(2*j), 1'b1);
            push_beat(2, 16'h0200 + 16'(2*j), 1'b0);
            push_beat(2, 16'h0201 + 16'(2*j), 1'b1);
        end
        exp_q.push_back(16'h0100); exp_q.push_back(16'h0101);
        exp_q.push_back(16'h0200); exp_q.push_back(16'h0201);
        exp_q.push_back(16'h0102); exp_q.push_back(16'h0103);
        exp_q.push_back(16'h0202); exp_q.push_back(16'h0203);
        drive_src();
        repeat (20) tick();
        check_logs("t2", 4'b0001, 4'b0100, 4'b0001, 4'b0100, 2, 2, 2, 2, 4);

        // req1 streams 20 beats without early last: bursts 8,8,4.
        clear_logs();
        for (int i = 0; i < 20; i++) begin
            push_beat(1, 16'h1000 + 16'(i), (i == 19));
            exp_q.push_back(16'h1000 + 16'(i));
        end
        drive_src();
        repeat (35) tick();
        check_logs("t3", 4'b0010, 4'b0010, 4'b0010, 4'b0000, 8, 8, 4, 0, 3);

        // req3 stalled by full for 5 cycles mid-burst; count must freeze.
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            push_beat(3, 16'h3300 + 16'(i), (i == 9));
            exp_q.push_back(16'h3300 + 16'(i));
        end
        drive_src();
        tick();
        check("t4_grant", grant, 4'b1000);
        check("t4_data0", wr_data, 16'h3300);
        repeat (3) tick();
        fifo_full = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_wren", wr_en, 0);
            check("t4_stall_ready", req_ready, 0);
            check("t4_stall_grant", grant, 4'b1000);
            tick();
        end
        fifo_full = 1'b0;
        #1;
        check("t4_resume_wren", wr_en, 1);
        check("t4_resume_data", wr_data, 16'h3303);
        repeat (20) tick();
        check_logs("t4", 4'b1000, 4'b1000, 4'b0000, 4'b0000, 8, 2, 0, 0, 2);

        // Reset pulse at beat 4 of 8; arbitration restarts from req0.
        push_beat(0, 16'h5000, 1'b1);
        exp_q.push_back(16'h5000);
        drive_src();
        repeat (4) tick();
        for (int i = 0; i < 8; i++) push_beat(2, 16'h5200 + 16'(i), (i == 7));
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h5200 + 16'(i));
        exp_q.push_back(16'h5001);
        exp_q.push_back(16'h5101);
        for (int i = 4; i < 8; i++) exp_q.push_back(16'h5200 + 16'(i));
        drive_src();
        tick();
        check("t5_grant", grant, 4'b0100);
        repeat (3) tick();
        check("t5_beat4", wr_data, 16'h5203);
        rst_n = 1'b0;
        push_beat(0, 16'h5001, 1'b1);
        push_beat(1, 16'h5101, 1'b1);
        drive_src();
        tick();
        check("t5_rst_grant", grant, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_wren", wr_en, 0);
        rst_n = 1'b1;
        tick();
        check("t5_post_grant", grant, 4'b0001);
        repeat (15) tick();
        check("t5_drain", exp_q.size(), 0);

`ifdef FIFO_WR_ARB_STALL_CNT_EN
        // Stall counter: 7 cycles, clear, then saturation.
        for (int i = 0; i < 3; i++) begin
            push_beat(1, 16'h7700 + 16'(i), (i == 2));
            exp_q.push_back(16'h7700 + 16'(i));
        end
        drive_src();
        tick();
        fifo_full = 1'b1;
        repeat (7) tick();
        check("sc_seven", stall_cnt, 7);
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        check("sc_clear", stall_cnt, 0);
        repeat (70000) tick();
        check("sc_sat", stall_cnt, 16'hFFFF);
        fifo_full = 1'b0;
        repeat (6) tick();
        check("sc_drain", exp_q.size(), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
